// File: rtl/exec_ctrl.sv
// Multi-cycle execute controller: IDLE -> DECODE -> EXEC -> WB, driving an external ALU.
// Define EXEC_CTRL_DBG_EN to add the dbg_addr/dbg_data register-file peek port.
module exec_ctrl #(
  parameter logic [15:0] REG_RESET   = 16'h0000,
  parameter logic [2:0]  HALT_OPCODE = 3'b111
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  output logic [15:0] alu_in_1,
  output logic [15:0] alu_in_2,
  output logic [3:0]  alu_op,
  input  logic [15:0] alu_out,
  input  logic        alu_zero,
  output logic        done,
  output logic        err,
  output logic        branch_taken,
  output logic [15:0] branch_offset,
  output logic        halted
`ifdef EXEC_CTRL_DBG_EN
  ,
  input  logic [2:0]  dbg_addr,
  output logic [15:0] dbg_data
`endif
);

  // ALU function codes shared with the ALU (simple/funct.vh encoding)
  localparam logic [3:0] FUNCT_ADD = 4'h0;
  localparam logic [3:0] FUNCT_SUB = 4'h1;
  localparam logic [3:0] FUNCT_AND = 4'h2;
  localparam logic [3:0] FUNCT_OR  = 4'h3;

  localparam logic [2:0] OP_RTYPE = 3'b000;
  localparam logic [2:0] OP_ADDI  = 3'b001;
  localparam logic [2:0] OP_BEQ   = 3'b010;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_WB     = 3'd3,
    S_HLT    = 3'd4
  } state_t;

  function automatic logic [15:0] sext7(input logic [6:0] v);
    return {{9{v[6]}}, v};
  endfunction

  state_t      state_r;
  state_t      next_state_s;
  logic [15:0] instr_r;
  logic [15:0] result_r;
  logic        ready_r;
  logic [15:0] regs_r [8];

  logic [2:0]  opcode_s;
  logic [2:0]  rs_s;
  logic [2:0]  rt_s;
  logic [2:0]  rd_s;
  logic [3:0]  funct_s;
  logic [15:0] imm_s;
  logic [15:0] src1_s;
  logic [15:0] src2_s;
  logic [3:0]  exec_op_s;
  logic        use_alu_s;
  logic        is_beq_s;
  logic        is_halt_s;
  logic        illegal_s;
  logic        wb_en_s;
  logic [2:0]  wb_addr_s;
  logic        funct_ok_s;

  // Field extraction and register-file reads for the latched instruction
  always_comb begin
    opcode_s = instr_r[15:13];
    rs_s     = instr_r[12:10];
    rt_s     = instr_r[9:7];
    rd_s     = instr_r[6:4];
    funct_s  = instr_r[3:0];
    imm_s    = sext7(instr_r[6:0]);
    src1_s   = (rs_s == 3'd0) ? 16'h0000 : regs_r[rs_s];
    src2_s   = (rt_s == 3'd0) ? 16'h0000 : regs_r[rt_s];
  end

  // Legal R-type function codes
  always_comb begin
    case (funct_s)
      FUNCT_ADD, FUNCT_SUB, FUNCT_AND, FUNCT_OR: funct_ok_s = 1'b1;
      default:                                   funct_ok_s = 1'b0;
    endcase
  end

  // Instruction class, ALU request and writeback target
  always_comb begin
    use_alu_s = 1'b0;
    is_beq_s  = 1'b0;
    is_halt_s = 1'b0;
    illegal_s = 1'b0;
    wb_en_s   = 1'b0;
    wb_addr_s = 3'd0;
    exec_op_s = FUNCT_ADD;
    if (opcode_s == HALT_OPCODE) begin
      is_halt_s = 1'b1;
    end else if (opcode_s == OP_RTYPE) begin
      if (funct_ok_s) begin
        use_alu_s = 1'b1;
        wb_en_s   = 1'b1;
        wb_addr_s = rd_s;
        exec_op_s = funct_s;
      end else begin
        illegal_s = 1'b1;
      end
    end else if (opcode_s == OP_ADDI) begin
      use_alu_s = 1'b1;
      wb_en_s   = 1'b1;
      wb_addr_s = rt_s;
      exec_op_s = FUNCT_ADD;
    end else if (opcode_s == OP_BEQ) begin
      use_alu_s = 1'b1;
      is_beq_s  = 1'b1;
      exec_op_s = FUNCT_SUB;
    end else begin
      illegal_s = 1'b1;
    end
  end

  // Next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (instr_valid) begin
          next_state_s = S_DECODE;
        end else begin
          next_state_s = S_IDLE;
        end
      end
      S_DECODE: next_state_s = S_EXEC;
      S_EXEC:   next_state_s = S_WB;
      S_WB: begin
        if (is_halt_s) begin
          next_state_s = S_HLT;
        end else begin
          next_state_s = S_IDLE;
        end
      end
      S_HLT:    next_state_s = S_HLT;
      default:  next_state_s = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Instruction latch, ALU drive and retirement outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_r       <= 16'h0000;
      result_r      <= 16'h0000;
      ready_r       <= 1'b1;
      alu_in_1      <= 16'h0000;
      alu_in_2      <= 16'h0000;
      alu_op        <= FUNCT_ADD;
      done          <= 1'b0;
      err           <= 1'b0;
      branch_taken  <= 1'b0;
      branch_offset <= 16'h0000;
      halted        <= 1'b0;
    end else begin
      ready_r       <= (next_state_s == S_IDLE);
      done          <= 1'b0;
      err           <= 1'b0;
      branch_taken  <= 1'b0;
      branch_offset <= 16'h0000;
      case (state_r)
        S_IDLE: begin
          if (instr_valid) begin
            instr_r <= instr;
          end
        end
        S_DECODE: begin
          // HALT and illegal words leave the ALU inputs untouched
          if (use_alu_s) begin
            alu_in_1 <= src1_s;
            alu_in_2 <= (opcode_s == OP_ADDI) ? imm_s : src2_s;
            alu_op   <= exec_op_s;
          end
        end
        S_EXEC: begin
          result_r      <= alu_out;
          done          <= 1'b1;
          err           <= illegal_s;
          branch_taken  <= is_beq_s & alu_zero;
          branch_offset <= imm_s;
          if (is_halt_s) begin
            halted <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Register file: r0 is hardwired to zero, single write port used only in WB
  always_ff @(posedge clk) begin
    if (reset) begin
      regs_r[0] <= 16'h0000;
      for (int i = 1; i < 8; i++) begin
        regs_r[i] <= REG_RESET;
      end
    end else if ((state_r == S_WB) && wb_en_s && (wb_addr_s != 3'd0)) begin
      regs_r[wb_addr_s] <= result_r;
    end
  end

  assign instr_ready = ready_r & ~reset;

`ifdef EXEC_CTRL_DBG_EN
  assign dbg_data = (dbg_addr == 3'd0) ? 16'h0000 : regs_r[dbg_addr];
`endif

endmodule

// File: tb/tb_exec_ctrl.sv
// Self-checking bench for exec_ctrl: directed plan plus random instruction mix against
// an instruction-level reference model; the bench also plays the ALU.
module tb_exec_ctrl;

  localparam logic [3:0] F_ADD = 4'h0;
  localparam logic [3:0] F_SUB = 4'h1;
  localparam logic [3:0] F_AND = 4'h2;
  localparam logic [3:0] F_OR  = 4'h3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] instr = 16'h0000;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [15:0] alu_in_1;
  logic [15:0] alu_in_2;
  logic [3:0]  alu_op;
  logic [15:0] alu_out;
  logic        alu_zero;
  logic        done;
  logic        err;
  logic        branch_taken;
  logic [15:0] branch_offset;
  logic        halted;
`ifdef EXEC_CTRL_DBG_EN
  logic [2:0]  dbg_addr = 3'd0;
  logic [15:0] dbg_data;
`endif

  int checks = 0;
  int errors = 0;

  logic [15:0] m_rf [8];
  logic [15:0] m_in1;
  logic [15:0] m_in2;
  logic [3:0]  m_op;
  logic        m_halted;

  exec_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .alu_in_1      (alu_in_1),
    .alu_in_2      (alu_in_2),
    .alu_op        (alu_op),
    .alu_out       (alu_out),
    .alu_zero      (alu_zero),
    .done          (done),
    .err           (err),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .halted        (halted)
`ifdef EXEC_CTRL_DBG_EN
    ,
    .dbg_addr      (dbg_addr),
    .dbg_data      (dbg_data)
`endif
  );

  always #5 clk = ~clk;

  // Stand-in ALU
  always_comb begin
    case (alu_op)
      F_ADD:   alu_out = alu_in_1 + alu_in_2;
      F_SUB:   alu_out = alu_in_1 - alu_in_2;
      F_AND:   alu_out = alu_in_1 & alu_in_2;
      F_OR:    alu_out = alu_in_1 | alu_in_2;
      default: alu_out = 16'h0000;
    endcase
    alu_zero = (alu_out == 16'h0000);
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_rf[i] = 16'h0000;
    m_in1 = 16'h0000;
    m_in2 = 16'h0000;
    m_op = F_ADD;
    m_halted = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    instr_valid = 1'b0;
    #1 check("ready_during_reset", instr_ready, 16'd0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    #1;
    check("rst_ready", instr_ready, 16'd1);
    check("rst_done", done, 16'd0);
    check("rst_err", err, 16'd0);
    check("rst_halted", halted, 16'd0);
    check("rst_taken", branch_taken, 16'd0);
    check("rst_offset", branch_offset, 16'h0000);
    check("rst_in1", alu_in_1, 16'h0000);
    check("rst_in2", alu_in_2, 16'h0000);
    check("rst_op", alu_op, {12'h000, F_ADD});
  endtask

  // Issue one instruction at a point where the controller should be idle, follow it to retirement
  task automatic run_instr(input logic [15:0] iw);
    logic [2:0]  op, rs, rt, rd;
    logic [3:0]  fn;
    logic [15:0] a, b, imm, res;
    logic        e_wb, e_err, e_taken, e_halt;
    logic [2:0]  e_waddr;
    op = iw[15:13]; rs = iw[12:10]; rt = iw[9:7]; rd = iw[6:4]; fn = iw[3:0];
    a = m_rf[rs]; b = m_rf[rt]; imm = {{9{iw[6]}}, iw[6:0]};
    res = 16'h0000; e_wb = 1'b0; e_err = 1'b0; e_taken = 1'b0; e_halt = 1'b0; e_waddr = 3'd0;
    case (op)
      3'b111: e_halt = 1'b1;
      3'b000: begin
        if (fn <= 4'd3) begin
          case (fn)
            F_ADD:   res = a + b;
            F_SUB:   res = a - b;
            F_AND:   res = a & b;
            default: res = a | b;
          endcase
          e_wb = 1'b1; e_waddr = rd;
          m_in1 = a; m_in2 = b; m_op = fn;
        end else begin
          e_err = 1'b1;
        end
      end
      3'b001: begin
        res = a + imm;
        e_wb = 1'b1; e_waddr = rt;
        m_in1 = a; m_in2 = imm; m_op = F_ADD;
      end
      3'b010: begin
        e_taken = (a == b);
        m_in1 = a; m_in2 = b; m_op = F_SUB;
      end
      default: e_err = 1'b1;
    endcase

    instr = iw;
    instr_valid = 1'b1;
    check("ready_idle", instr_ready, 16'd1);
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    #1;
    check("decode_done", done, 16'd0);
    check("decode_ready", instr_ready, 16'd0);
    @(negedge clk);
    #1;
    check("exec_in1", alu_in_1, m_in1);
    check("exec_in2", alu_in_2, m_in2);
    check("exec_op", alu_op, {12'h000, m_op});
    check("exec_done", done, 16'd0);
    @(negedge clk);
    #1;
    check("wb_done", done, 16'd1);
    check("wb_err", err, {15'd0, e_err});
    check("wb_taken", branch_taken, {15'd0, e_taken});
    check("wb_offset", branch_offset, imm);
    check("wb_halted", halted, {15'd0, e_halt | m_halted});
    if (e_wb && e_waddr != 3'd0) m_rf[e_waddr] = res;
    if (e_halt) m_halted = 1'b1;
    @(negedge clk);
    #1;
    check("post_done", done, 16'd0);
    check("post_err", err, 16'd0);
    check("post_ready", instr_ready, {15'd0, ~m_halted});
`ifdef EXEC_CTRL_DBG_EN
    dbg_addr = 3'($urandom_range(0, 7));
    #1 check("dbg_read", dbg_data, m_rf[dbg_addr]);
`endif
  endtask

  initial begin
    logic [2:0]  rs_v, rt_v, rd_v;
    logic [6:0]  imm_v;
    logic [15:0] iw_v;
    int          sel;

    model_reset();
    do_reset();

    run_instr(16'h2085);                 // ADDI r1,r0,5
    run_instr(16'h217D);                 // ADDI r2,r0,-3
    run_instr(16'h0530);                 // ADD r3,r1,r2 -> 2
    run_instr(16'h4D80);                 // BEQ r3,r3 exposes r3
    run_instr(16'h0531);                 // SUB r3,r1,r2 -> 8
    run_instr(16'h4D80);
    run_instr(16'h4484);                 // BEQ r1,r1,+4 taken
    run_instr(16'h4500);                 // BEQ r1,r2 not taken
    run_instr(16'h6530);                 // opcode 011 illegal
    run_instr(16'h053F);                 // undefined funct
    run_instr(16'h2407);                 // ADDI r0,r1,7 dropped
    run_instr(16'h4080);                 // BEQ r0,r1 exposes r0
    run_instr(16'h0510);                 // ADD r1,r1,r2 (rd==rs)
    run_instr(16'h4484);

    for (int k = 0; k < 60; k++) begin
      sel   = $urandom_range(0, 9);
      rs_v  = 3'($urandom_range(0, 7));
      rt_v  = 3'($urandom_range(0, 7));
      rd_v  = 3'($urandom_range(0, 7));
      imm_v = 7'($urandom_range(0, 127));
      if (sel < 4) begin
        iw_v = {3'b000, rs_v, rt_v, rd_v, 4'($urandom_range(0, 5))};
      end else if (sel < 6) begin
        iw_v = {3'b001, rs_v, rt_v, imm_v};
      end else if (sel < 8) begin
        if (sel == 6) rt_v = rs_v;
        iw_v = {3'b010, rs_v, rt_v, imm_v};
      end else begin
        iw_v = {3'($urandom_range(3, 6)), rs_v, rt_v, imm_v};
      end
      run_instr(iw_v);
    end

    // Reset while ADDI r1,r0,5 is in EXEC: no done, no writeback
    run_instr(16'h2089);                 // r1 = 9
    instr = 16'h2085;
    instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1 check("abort_exec_done", done, 16'd0);
    @(negedge clk);
    #1 check("abort_wb_done", done, 16'd0);
    reset = 1'b0;
    model_reset();
    #1;
    check("abort_ready", instr_ready, 16'd1);
    check("abort_in1", alu_in_1, 16'h0000);
`ifdef EXEC_CTRL_DBG_EN
    dbg_addr = 3'd1;
    #1 check("abort_dbg_r1", dbg_data, 16'h0000);
`endif
    run_instr(16'h4484);                 // r1 must read REG_RESET
    run_instr(16'h217D);

    // HALT is terminal until reset
    run_instr(16'hE000);
    instr = 16'h2085;
    instr_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      check("hlt_ready", instr_ready, 16'd0);
      check("hlt_done", done, 16'd0);
      check("hlt_halted", halted, 16'd1);
    end
    do_reset();
    run_instr(16'h2085);
    run_instr(16'h4484);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
